alu_exec_unit: RTL
==================

Name: alu_exec_unit

Overview:
- Execute-stage ALU that sits directly downstream of the ALU control decoder and consumes its 4-bit ALUCtrl code together with the two register/immediate operands.
- AND, OR, ADD, SUB and SLT complete in one cycle.
- SLL, SRL and SRA run bit-serially, one bit position per cycle, to save area.
- A start/done handshake lets the core controller stall while a shift is in progress.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, width of the shift amount field taken from B[SHAMT_W-1:0]; must equal log2(WIDTH).

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request to execute; accepted only when Ready=1.
- ALUCtrl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 SLL, 1001 SRL, 1010 SRA.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; B[SHAMT_W-1:0] is the shift amount for shift ops.
- Ready  output  1  high when the unit is idle and can accept Start (combinational from state).
- Done  output  1  one-cycle pulse; Result, Zero and IllegalOp are valid in this cycle.
- Result  output  WIDTH  registered result, held until the next Done.
- Zero  output  1  registered, equals (Result == 0); feeds branch decision.
- IllegalOp  output  1  registered; set with Done when ALUCtrl is not a listed code.

Behaviour:
- Reset (async, Rst_n=0):
  - State=IDLE, Result=0, Zero=1, Done=0, IllegalOp=0, shift counter=0, working register=0.
  - Ready=1 once reset is released.
  - Reset during SHIFT aborts the operation; no Done is produced.
- States are IDLE and SHIFT.
- Ready=1 iff state=IDLE. Start while Ready=0 is ignored and has no side effects.
- Operands and ALUCtrl are sampled only at the accepting edge (Start=1, state=IDLE). Later input changes do not affect an operation in flight.
- Single-cycle ops (AND, OR, ADD, SUB, SLT, a shift with amount 0, and illegal codes):
  - Accepted at edge k; Result, Zero and Done are updated at edge k, so Done is high during cycle k+1.
  - State remains IDLE, giving a throughput of one op per cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH; there is no overflow flag.
  - SLT is a signed compare: Result = {WIDTH-1 zeros, (A<B signed)}.
- Shift ops with amount n>0:
  - At the accepting edge, load the working register with A, load counter=n, and go to SHIFT.
  - Each SHIFT edge shifts the working register by 1 and decrements the counter. SLL inserts 0 at the LSB, SRL inserts 0 at the MSB, SRA replicates the MSB.
  - On the edge where the counter goes 1->0: write Result and Zero, pulse Done, return to IDLE.
  - Total latency: accepted at edge k, Done high during cycle k+n+1. Ready returns to 1 in that same Done cycle, so a back-to-back Start is accepted at edge k+n+1.
  - Maximum latency is 2^SHAMT_W-1 shift cycles.
- Illegal ALUCtrl: Result=0, Zero=1, IllegalOp=1, all in the Done cycle. IllegalOp clears on the next Done.
- Done is 0 in every cycle that is not a completion cycle. Result, Zero and IllegalOp hold their values between Done pulses.
- Start asserted in the Done cycle of a shift is legal and is accepted at that edge.

Test Plan:
- Reset then idle: hold Rst_n=0 for 3 cycles, release -> Result=0, Zero=1, Done=0, Ready=1, IllegalOp=0.
- Single-cycle sequence: back-to-back Starts, one per cycle, ADD A=5 B=7; SUB A=3 B=3; AND A=0xF0F0 B=0x0FF0; OR A=0xF0 B=0x0F; SLT A=-1 B=1 -> Done in 5 consecutive cycles with Results 12, 0 (Zero=1), 0x00F0, 0xFF, 1.
- Shifts:
  - SLL A=1 B=31 -> Ready=0 for 31 cycles, Done after edge k+31, Result=0x80000000.
  - SRA A=0x80000000 B=4 -> Result=0xF8000000.
  - SRL same operands -> Result=0x08000000.
  - Shift with B[4:0]=0 -> 1-cycle, Result=A.
- Stall, busy-ignore and back-to-back: during SLL A=3 B=8, pulse Start with ADD A=1 B=1 and toggle A and B -> ADD ignored, Result=0x300. A Start of ADD A=1 B=1 held in the Done cycle is accepted, and Result=2 appears next cycle.
- Illegal code: ALUCtrl=1111 A=9 B=9 -> Done, IllegalOp=1, Result=0, Zero=1. The next legal ADD clears IllegalOp.
- Reset mid-shift: start SRL A=0xFFFF0000 B=20, assert Rst_n=0 at shift cycle 5 -> outputs take reset values immediately with no Done. After release, ADD A=2 B=2 gives Result=4 after 1 cycle.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Start/done handshake and operand bus between core controller and ALU.
// master drives the request, slave returns the result.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [3:0]       ALUCtrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ready;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             IllegalOp;

  modport master (
    output Start, ALUCtrl, A, B,
    input  Ready, Done, Result, Zero, IllegalOp
  );

  modport slave (
    input  Start, ALUCtrl, A, B,
    output Ready, Done, Result, Zero, IllegalOp
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: logic/arith ops in one cycle,
// shifts bit-serial one position per cycle behind a start/done handshake.
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input logic            Clk,
  input logic            Rst_n,
  alu_exec_unit_if.slave bus
);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  localparam logic [1:0] K_SLL = 2'd0;
  localparam logic [1:0] K_SRL = 2'd1;
  localparam logic [1:0] K_SRA = 2'd2;

  state_t             r_state;
  state_t             w_next;
  logic [SHAMT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_work;
  logic [1:0]         r_kind;
  logic [WIDTH-1:0]   r_result;
  logic               r_zero;
  logic               r_done;
  logic               r_ill;

  logic               w_accept;
  logic               w_last;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic               w_ill;
  logic               w_is_shift;
  logic [1:0]         w_kind;
  logic               w_long;
  logic [WIDTH-1:0]   w_shifted;

  assign w_shamt  = bus.B[SHAMT_W-1:0];
  assign w_accept = bus.Start && (r_state == S_IDLE);
  assign w_last   = (r_cnt == SHAMT_W'(1));
  assign w_long   = w_is_shift && (w_shamt != '0);

  always_comb begin
    w_res      = '0;
    w_ill      = 1'b0;
    w_is_shift = 1'b0;
    w_kind     = K_SLL;
    case (bus.ALUCtrl)
      4'b0000: w_res = bus.A & bus.B;
      4'b0001: w_res = bus.A | bus.B;
      4'b0010: w_res = bus.A + bus.B;
      4'b0110: w_res = bus.A - bus.B;
      4'b0111: w_res = {{(WIDTH-1){1'b0}},
                        $signed(bus.A) < $signed(bus.B)};
      4'b1000: begin
        w_is_shift = 1'b1;
        w_kind     = K_SLL;
        w_res      = bus.A;
      end
      4'b1001: begin
        w_is_shift = 1'b1;
        w_kind     = K_SRL;
        w_res      = bus.A;
      end
      4'b1010: begin
        w_is_shift = 1'b1;
        w_kind     = K_SRA;
        w_res      = bus.A;
      end
      default: w_ill = 1'b1;
    endcase
  end

  always_comb begin
    w_shifted = {r_work[WIDTH-2:0], 1'b0};
    case (r_kind)
      K_SRL:   w_shifted = {1'b0, r_work[WIDTH-1:1]};
      K_SRA:   w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
      default: w_shifted = {r_work[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_long) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.Ready = (r_state == S_IDLE);
  end

  // Zero-amount shifts and illegal codes complete like any one-cycle op.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_cnt    <= '0;
      r_work   <= '0;
      r_kind   <= K_SLL;
      r_result <= '0;
      r_zero   <= 1'b1;
      r_done   <= 1'b0;
      r_ill    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        if (w_long) begin
          r_work <= bus.A;
          r_cnt  <= w_shamt;
          r_kind <= w_kind;
        end else begin
          r_result <= w_res;
          r_zero   <= (w_res == '0);
          r_ill    <= w_ill;
          r_done   <= 1'b1;
        end
      end else if (r_state == S_SHIFT) begin
        r_work <= w_shifted;
        r_cnt  <= r_cnt - SHAMT_W'(1);
        if (w_last) begin
          r_result <= w_shifted;
          r_zero   <= (w_shifted == '0);
          r_ill    <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign bus.Done      = r_done;
  assign bus.Result    = r_result;
  assign bus.Zero      = r_zero;
  assign bus.IllegalOp = r_ill;

endmodule
